// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states and bit-timing constants.
// Imported by the transmitter now and by the receiver once it migrates.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam int OVERSAMPLE = 16;

   localparam int STOP_1   = 16;
   localparam int STOP_1P5 = 24;
   localparam int STOP_2   = 32;

   // Whole frame length in s_tick pulses.
   function automatic int frame_ticks(
      input int dbit,
      input int par_en,
      input int sb_tick
   );
      return OVERSAMPLE * (1 + dbit + par_en) + sb_tick;
   endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start, DBIT data bits LSB first, optional parity, stop.
// Timing from the shared 16x s_tick; tx is a registered line.
module uart_tx
   import uart_pkg::*;
#(
   parameter int DBIT       = 8,
   parameter int SB_TICK    = STOP_1,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       tx_start,
   input  logic       s_tick,
   input  logic [7:0] din,
   output logic       tx_busy,
   output logic       tx_done_tick,
   output logic       tx
);

   localparam logic [4:0] BIT_LAST  = 5'(OVERSAMPLE - 1);
   localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
   localparam logic [2:0] N_LAST    = 3'(DBIT - 1);
   localparam logic       P_INIT    = 1'(PARITY_ODD);
   localparam logic       P_EN      = (PARITY_EN != 0);

   tx_state_t  state_q;
   logic [4:0] s_q;
   logic [2:0] n_q;
   logic [7:0] b_q;
   logic       p_q;
   logic       tx_q;
   logic       tx_d;

   // Line level for the current state; lands on tx one clock later.
   always_comb begin
      tx_d = 1'b1;
      unique case (state_q)
         IDLE:    tx_d = 1'b1;
         START:   tx_d = 1'b0;
         DATA:    tx_d = b_q[0];
         PARITY:  tx_d = p_q;
         STOP:    tx_d = 1'b1;
         default: tx_d = 1'b1;
      endcase
   end

   // Frame sequencer: tick counting, bit counting, shifting, parity.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         s_q     <= '0;
         n_q     <= '0;
         b_q     <= '0;
         p_q     <= 1'b0;
         tx_q    <= 1'b1;
      end else begin
         tx_q <= tx_d;
         unique case (state_q)
            IDLE: begin
               if (tx_start) begin
                  b_q     <= din;
                  s_q     <= '0;
                  p_q     <= P_INIT;
                  state_q <= START;
               end
            end
            START: begin
               if (s_tick) begin
                  if (s_q == BIT_LAST) begin
                     s_q     <= '0;
                     n_q     <= '0;
                     state_q <= DATA;
                  end else begin
                     s_q <= s_q + 5'd1;
                  end
               end
            end
            DATA: begin
               if (s_tick) begin
                  if (s_q == BIT_LAST) begin
                     s_q <= '0;
                     b_q <= b_q >> 1;
                     p_q <= p_q ^ b_q[0];
                     if (n_q == N_LAST) begin
                        state_q <= P_EN ? PARITY : STOP;
                     end else begin
                        n_q <= n_q + 3'd1;
                     end
                  end else begin
                     s_q <= s_q + 5'd1;
                  end
               end
            end
            PARITY: begin
               if (s_tick) begin
                  if (s_q == BIT_LAST) begin
                     s_q     <= '0;
                     state_q <= STOP;
                  end else begin
                     s_q <= s_q + 5'd1;
                  end
               end
            end
            STOP: begin
               if (s_tick) begin
                  if (s_q == STOP_LAST) begin
                     s_q     <= '0;
                     state_q <= IDLE;
                  end else begin
                     s_q <= s_q + 5'd1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign tx_busy      = (state_q != IDLE);
   assign tx_done_tick = (state_q == STOP) && s_tick && (s_q == STOP_LAST);
   assign tx           = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: three parameterisations, frame-level model.
// Model tracks ticks consumed per frame and derives the line level from it.
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       tx_start;
   logic       s_tick;
   logic [7:0] din;
   logic       tx_w   [3];
   logic       busy_w [3];
   logic       done_w [3];

   int checks = 0;
   int errors = 0;
   int tick_mode = 0;

   always #5 clk = ~clk;

   uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) u0 (
      .clk(clk), .reset_n(reset_n), .tx_start(tx_start), .s_tick(s_tick),
      .din(din), .tx_busy(busy_w[0]), .tx_done_tick(done_w[0]), .tx(tx_w[0])
   );

   uart_tx #(.DBIT(8), .SB_TICK(24), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
      .clk(clk), .reset_n(reset_n), .tx_start(tx_start), .s_tick(s_tick),
      .din(din), .tx_busy(busy_w[1]), .tx_done_tick(done_w[1]), .tx(tx_w[1])
   );

   uart_tx #(.DBIT(5), .SB_TICK(32), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
      .clk(clk), .reset_n(reset_n), .tx_start(tx_start), .s_tick(s_tick),
      .din(din), .tx_busy(busy_w[2]), .tx_done_tick(done_w[2]), .tx(tx_w[2])
   );

   function automatic int p_db(input int i);
      return (i == 2) ? 5 : 8;
   endfunction

   function automatic int p_sb(input int i);
      return (i == 0) ? 16 : (i == 1) ? 24 : 32;
   endfunction

   function automatic int p_pe(input int i);
      return (i == 0) ? 0 : 1;
   endfunction

   function automatic int p_po(input int i);
      return (i == 2) ? 1 : 0;
   endfunction

   function automatic int len_lit(input int i);
      return (i == 0) ? 160 : (i == 1) ? 184 : 144;
   endfunction

   function automatic int flen(input int i);
      return 16 * (1 + p_db(i) + p_pe(i)) + p_sb(i);
   endfunction

   function automatic logic par(input int i, input logic [7:0] d);
      int ones = 0;
      for (int j = 0; j < p_db(i); j++) ones += int'(d[j]);
      return ((p_po(i) + ones) % 2) == 1;
   endfunction

   // Ideal line level once k ticks of the frame have elapsed.
   function automatic logic line(input int i, input logic [7:0] d, input int k);
      int seg = k / 16;
      if (seg == 0) return 1'b0;
      if (seg <= p_db(i)) return d[seg-1];
      if (p_pe(i) == 1 && seg == p_db(i) + 1) return par(i, d);
      return 1'b1;
   endfunction

   task automatic chk(input string nm, input int i, input logic a, input logic e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s[%0d] t=%0t got=%b want=%b", nm, i, $time, a, e);
      end
   endtask

   task automatic chk_int(input string nm, input int i, input int a, input int e);
      checks++;
      if (a != e) begin
         errors++;
         $display("FAIL %s[%0d] t=%0t got=%0d want=%0d", nm, i, $time, a, e);
      end
   endtask

   logic       act  [3];
   int         k    [3];
   logic [7:0] dat  [3];
   logic       etx  [3];
   int         tcnt [3];
   int         done_cnt [3];
   logic [7:0] acc0 [$];

   initial begin
      for (int i = 0; i < 3; i++) begin
         act[i] = 1'b0; k[i] = 0; dat[i] = '0; etx[i] = 1'b1;
         tcnt[i] = 0; done_cnt[i] = 0;
      end
   end

   // Compare DUT outputs to the model each cycle, then advance the model.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         logic nx;
         int   len;
         len = flen(i);
         if (!reset_n) begin
            act[i] = 1'b0; k[i] = 0; etx[i] = 1'b1;
         end
         chk("tx", i, tx_w[i], etx[i]);
         chk("busy", i, busy_w[i], act[i]);
         chk("done", i, done_w[i], act[i] && s_tick && (k[i] == len - 1));
         if (done_w[i] === 1'b1) begin
            done_cnt[i]++;
            chk_int("frame_ticks", i, tcnt[i] + int'(s_tick), len_lit(i));
         end
         nx = act[i] ? line(i, dat[i], k[i]) : 1'b1;
         if (reset_n) begin
            if (act[i]) begin
               if (s_tick) begin
                  tcnt[i]++;
                  if (k[i] == len - 1) act[i] = 1'b0;
                  else k[i]++;
               end
            end else if (tx_start) begin
               act[i] = 1'b1; k[i] = 0; dat[i] = din; tcnt[i] = 0;
               if (i == 0) acc0.push_back(din);
            end
         end
         etx[i] = nx;
      end
   end

   // s_tick driver: alternating, random, or continuous.
   initial begin
      s_tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (tick_mode)
            0: s_tick = ~s_tick;
            1: s_tick = ($urandom % 3) == 0;
            default: s_tick = 1'b1;
         endcase
      end
   end

   task automatic pulse(input logic [7:0] d);
      @(posedge clk); #1;
      tx_start = 1'b1; din = d;
      @(posedge clk); #1;
      tx_start = 1'b0;
   endtask

   task automatic wait_idle(input int maxc);
      int c = 0;
      @(negedge clk);
      while ((busy_w[0] | busy_w[1] | busy_w[2]) && c < maxc) begin
         @(negedge clk);
         c++;
      end
      checks++;
      if (c >= maxc) begin
         errors++;
         $display("FAIL wait_idle timeout t=%0t", $time);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] exp_a5;
      logic [9:0] got_a5;
      int c;

      reset_n = 1'b0; tx_start = 1'b0; din = '0;
      exp_a5 = 10'b1101001010;
      for (int j = 0; j < 10; j++) got_a5[j] = line(0, 8'hA5, 16 * j);
      chk_int("model_a5_bits", 0, int'(got_a5), int'(exp_a5));
      chk("model_par_even_07", 1, par(1, 8'h07), 1'b1);
      chk("model_par_odd_07", 2, par(2, 8'h07), 1'b0);
      for (int i = 0; i < 3; i++) chk_int("model_len", i, flen(i), len_lit(i));

      repeat (4) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (3) @(posedge clk);

      // A5 with an ignored mid-frame request, then back-to-back 3C.
      pulse(8'hA5);
      c = 0;
      while (k[0] < 40 && c < 1000) begin @(negedge clk); c++; end
      chk_int("reach_mid", 0, int'(c < 1000), 1);
      pulse(8'h3C);
      c = 0;
      @(negedge clk);
      while (done_w[0] !== 1'b1 && c < 1000) begin @(negedge clk); c++; end
      chk_int("a5_done_seen", 0, int'(c < 1000), 1);
      @(posedge clk); #1;
      tx_start = 1'b1; din = 8'h3C;
      @(posedge clk); #1;
      tx_start = 1'b0; din = 8'hFF;
      wait_idle(2000);
      chk_int("done_count_u0", 0, done_cnt[0], 2);
      chk_int("acc0_len", 0, acc0.size(), 2);
      if (acc0.size() == 2) begin
         chk_int("acc0_first", 0, int'(acc0[0]), 32'hA5);
         chk_int("acc0_second", 0, int'(acc0[1]), 32'h3C);
      end

      // Parity frames and the long stop period.
      pulse(8'h07);
      wait_idle(2000);
      pulse(8'h00);
      wait_idle(2000);

      // Reset during data bit 3 of u0.
      pulse(8'($urandom));
      c = 0;
      while (!(act[0] && k[0] >= 70) && c < 1000) begin @(negedge clk); c++; end
      chk_int("reach_bit3", 0, int'(c < 1000), 1);
      @(posedge clk); #1 reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (2) @(posedge clk);
      pulse(8'h5A);
      wait_idle(2000);

      // Random traffic with random and continuous ticks.
      tick_mode = 1;
      repeat (12000) begin
         @(posedge clk); #1;
         tx_start = ($urandom % 50) == 0;
         din = 8'($urandom);
      end
      tick_mode = 2;
      repeat (6000) begin
         @(posedge clk); #1;
         tx_start = ($urandom % 20) == 0;
         din = 8'($urandom);
      end
      tx_start = 1'b0;
      wait_idle(3000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
